fetch_seq_ctrl: RTL
===================

FETCH_SEQ_CTRL -- requirements
Module: fetch_seq_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h1eceb000, is the fetch address loaded at reset.
REQ-002 Parameter CNT_W, default 16, is the width of the redirect/squash statistics counters.
REQ-003 Port clk  input  1  is the single clock; all state updates SHALL occur on its rising edge.
REQ-004 Port rst_n  input  1  is the synchronous active-low reset, sampled on the clk rising edge.
REQ-005 Port imem_addr  output  32  is the fetch address, word-aligned.
REQ-006 Port imem_rmask  output  4  is 4'hf while a request is presented, else 4'h0.
REQ-007 Port imem_rdata  input  32  is the fetched instruction, valid with imem_resp.
REQ-008 Port imem_resp  input  1  is the single-cycle response strobe for the outstanding request.
REQ-009 Port pd_inst / pd_pc  output  32 each  carry the instruction and PC to the branch predecoder (combinational pass-through of imem_rdata and the request PC).
REQ-010 Port pd_valid  input  1  is the predecoder redirect flag (jal/jalr/branch) for pd_inst.
REQ-011 Port pd_target  input  32  is the predecoder target, valid when pd_valid=1.
REQ-012 Port br_mispredict / br_target  input  1 / 32  carry the backend redirect and its correct PC.
REQ-013 Port iq_full  input  1  indicates the instruction queue cannot accept one more entry.
REQ-014 Port iq_push / iq_inst / iq_pc / iq_pc_next  output  1/32/32/32  push one fetched instruction, its PC, and its predicted next PC.
REQ-015 Port redirect_cnt / squash_cnt  output  CNT_W each  count accepted predecoder redirects and discarded responses.

Function
REQ-016 The block SHALL hold at most one outstanding imem request; FSM states: IDLE, REQ, SQUASH.
REQ-017 IDLE: imem_rmask=0; when iq_full=0, go to REQ next cycle; the request is presented in REQ.
REQ-018 REQ/SQUASH: imem_rmask=4'hf, and imem_addr SHALL stay equal to the issue PC until imem_resp.
REQ-019 REQ with imem_resp=1 and br_mispredict=0: assert iq_push for exactly that cycle with iq_inst=imem_rdata, iq_pc=fetch PC, iq_pc_next=(pd_valid ? pd_target : fetch PC+4), and load the fetch PC with iq_pc_next.
REQ-020 After REQ-019, next state SHALL be REQ if iq_full=0 that cycle, else IDLE; back-to-back requests therefore have zero idle cycles.
REQ-021 PC+4 SHALL wrap modulo 2^32; pd_target and br_target SHALL be used with bits [1:0] forced to 0.
REQ-022 br_mispredict has priority over every other event in every state; it loads the fetch PC with br_target.
REQ-023 br_mispredict in IDLE: load PC and stay in IDLE (REQ-017 applies next cycle).
REQ-024 br_mispredict in REQ without imem_resp: go to SQUASH; the stale request address stays on imem_addr until its response.
REQ-025 br_mispredict in REQ with imem_resp in the same cycle: no iq_push, pd_valid ignored, increment squash_cnt, next state per REQ-020 using the new PC.
REQ-026 SQUASH with imem_resp: discard the data (no iq_push), increment squash_cnt, go to REQ if iq_full=0, else IDLE; the new request uses the redirected PC.
REQ-027 br_mispredict in SQUASH: overwrite the redirected PC, stay in SQUASH; the last br_target wins.
REQ-028 redirect_cnt SHALL increment once per iq_push with pd_valid=1; both counters SHALL saturate at all-ones.
REQ-029 iq_push SHALL never be asserted when not in REQ or when imem_resp=0.

Reset
REQ-030 While rst_n=0: state=IDLE, fetch PC=RESET_PC, imem_rmask=0, iq_push=0, counters=0, and any in-flight response is ignored.
REQ-031 With iq_full=0, the first request (imem_addr=RESET_PC) SHALL appear two cycles after rst_n rises (IDLE then REQ).

Verification
REQ-032 Reset release, iq_full=0, and a memory with 1-cycle latency returning NOPs -> addresses 1eceb000, 1eceb004, 1eceb008 with one push per response and no gaps.
REQ-033 Response at PC 1eceb010 with pd_valid=1 and pd_target=1eceb100 -> iq_pc_next=1eceb100, next imem_addr=1eceb100, redirect_cnt=1.
REQ-034 br_mispredict with br_target=1eceb200 two cycles before a 3-cycle response -> SQUASH, no push for the stale data, squash_cnt=1, next imem_addr=1eceb200.
REQ-035 br_mispredict coincident with imem_resp and pd_valid=1 -> no push, redirect_cnt unchanged, next address equals br_target.
REQ-036 iq_full=1 at response time -> push occurs, then IDLE with imem_rmask=0 until iq_full falls, then the request resumes at the held PC.
REQ-037 rst_n=0 asserted mid-request, then released -> all outputs per REQ-030, the late stale imem_resp produces no push, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: keeps one imem request in flight, follows predecoder
// redirects and backend mispredicts, and pushes fetched instructions into the queue.
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  output logic [3:0]       imem_rmask,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_resp,
  output logic [31:0]      pd_inst,
  output logic [31:0]      pd_pc,
  input  logic             pd_valid,
  input  logic [31:0]      pd_target,
  input  logic             br_mispredict,
  input  logic [31:0]      br_target,
  input  logic             iq_full,
  output logic             iq_push,
  output logic [31:0]      iq_inst,
  output logic [31:0]      iq_pc,
  output logic [31:0]      iq_pc_next,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] squash_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, SQUASH} state_e;

  state_e           state_q;
  logic [31:0]      addr_q;
  logic [31:0]      pc_q;
  logic [CNT_W-1:0] rcnt_q;
  logic [CNT_W-1:0] scnt_q;

  logic [31:0]      pred_next;
  logic [31:0]      br_pc;
  logic [31:0]      squash_pc;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign br_pc     = word_align(br_target);
  assign pred_next = pd_valid ? word_align(pd_target) : addr_q + 32'd4;
  // A mispredict arriving with the squashed response still wins for the restart PC.
  assign squash_pc = br_mispredict ? br_pc : pc_q;

  assign imem_addr    = addr_q;
  assign imem_rmask   = (rst_n && state_q != IDLE) ? 4'hf : 4'h0;
  assign pd_inst      = imem_rdata;
  assign pd_pc        = addr_q;
  assign iq_push      = rst_n && (state_q == REQ) && imem_resp && !br_mispredict;
  assign iq_inst      = imem_rdata;
  assign iq_pc        = addr_q;
  assign iq_pc_next   = pred_next;
  assign redirect_cnt = rcnt_q;
  assign squash_cnt   = scnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= word_align(RESET_PC);
      addr_q  <= word_align(RESET_PC);
      rcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (br_mispredict) begin
            pc_q <= br_pc;
          end else if (!iq_full) begin
            state_q <= REQ;
            addr_q  <= pc_q;
          end
        end
        REQ: begin
          if (br_mispredict) begin
            pc_q <= br_pc;
            if (imem_resp) begin
              scnt_q  <= sat_inc(scnt_q);
              addr_q  <= br_pc;
              state_q <= iq_full ? IDLE : REQ;
            end else begin
              state_q <= SQUASH;
            end
          end else if (imem_resp) begin
            pc_q    <= pred_next;
            addr_q  <= pred_next;
            state_q <= iq_full ? IDLE : REQ;
            if (pd_valid) rcnt_q <= sat_inc(rcnt_q);
          end
        end
        SQUASH: begin
          if (br_mispredict) pc_q <= br_pc;
          if (imem_resp) begin
            scnt_q  <= sat_inc(scnt_q);
            addr_q  <= squash_pc;
            state_q <= iq_full ? IDLE : REQ;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
